// File: rtl/mc_cpu_core_if.sv
// mc_cpu_core_if: instruction-fetch request/acknowledge bus between core and instruction memory
interface mc_cpu_core_if #(parameter int PC_W = 16);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_rdata;
  modport master(output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave(input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/mc_cpu_core.sv
// mc_cpu_core: multicycle FETCH/EXEC core with 16-bit instructions and an 8-entry register file
module mc_cpu_core #(
  parameter int DATA_W = 16,
  parameter int PC_W = 16,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mc_cpu_core_if.master     imem,
  output logic              retire,
  output logic              halted,
  output logic              zero_flag,
  output logic              carry_flag,
  input  logic [2:0]        dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
);
  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;
  state_t state;
  logic req;
  logic [15:0] ir;
  logic [PC_W-1:0] pc, pc_next, imm_p;
  logic [DATA_W-1:0] regs [8];
  logic [2:0] op, rd, rs1, rs2, sel;
  logic [3:0] fn;
  logic [DATA_W-1:0] a, b, d, imm_d, res;
  logic [DATA_W:0] sum;
  logic addi, wr_en, rf_we, carry;
  assign {op, rd, rs1, rs2, fn} = ir;
  assign imm_d = {{(DATA_W-7){ir[6]}}, ir[6:0]};
  assign imm_p = {{(PC_W-7){ir[6]}}, ir[6:0]};
  assign a = regs[rs1];
  assign b = regs[rs2];
  assign d = regs[rd];
  assign imem.imem_req = req;
  assign imem.imem_addr = pc;
  assign dbg_rdata = regs[dbg_raddr];
  // ADDI shares the ADD path; r0 stays zero because its storage is never written
  always_comb begin
    addi = op == 3'b001;
    sel = addi ? 3'd0 : fn[2:0];
    sum = {1'b0, a} + {1'b0, addi ? imm_d : b};
    res = sel == 3'd0 ? sum[DATA_W-1:0] :
          sel == 3'd1 ? a - b :
          sel == 3'd2 ? a & b :
          sel == 3'd3 ? a | b :
          sel == 3'd4 ? a ^ b :
          sel == 3'd5 ? {{(DATA_W-1){1'b0}}, a < b} :
          sel == 3'd6 ? a << b[3:0] : a >> b[3:0];
    carry = sel == 3'd0 ? sum[DATA_W] : (sel == 3'd1 && a < b);
    wr_en = addi || (op == 3'b000 && !fn[3]);
    rf_we = wr_en && !(ZERO_REG != 0 && rd == 3'd0);
    pc_next = op == 3'b010 ? pc + PC_W'(1) + (d == a ? imm_p : '0) :
              op == 3'b011 ? PC_W'(ir[12:0]) :
              op == 3'b111 ? pc : pc + PC_W'(1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      req <= 1'b0;
      pc <= '0;
      ir <= '0;
      retire <= 1'b0;
      halted <= 1'b0;
      zero_flag <= 1'b0;
      carry_flag <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (req && imem.imem_ack) begin
            ir <= imem.imem_rdata;
            req <= 1'b0;
            retire <= 1'b1;
            state <= EXEC;
          end else req <= 1'b1;
        end
        EXEC: begin
          retire <= 1'b0;
          pc <= pc_next;
          if (rf_we) regs[rd] <= res;
          if (wr_en) begin
            zero_flag <= res == '0;
            carry_flag <= carry;
          end
          if (op == 3'b111) begin
            halted <= 1'b1;
            state <= HALT;
          end else begin
            req <= 1'b1;
            state <= FETCH;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_cpu_core.sv
// tb_mc_cpu_core: randomized and directed checks of mc_cpu_core against an instruction-level model
module tb_mc_cpu_core;
  logic clk = 0;
  logic rst_n = 1;
  always #10 clk = ~clk;
  mc_cpu_core_if #(.PC_W(16)) bus();
  mc_cpu_core_if #(.PC_W(8)) bus2();
  logic retire, halted, zf, cf, retire2, halted2, zf2, cf2;
  logic [2:0] dbg_raddr = 0, dbg_raddr2 = 0;
  logic [15:0] dbg_rdata, dbg_rdata2;
  mc_cpu_core #(.DATA_W(16), .PC_W(16), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .imem(bus.master), .retire(retire), .halted(halted),
    .zero_flag(zf), .carry_flag(cf), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata));
  mc_cpu_core #(.DATA_W(16), .PC_W(8), .ZERO_REG(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .imem(bus2.master), .retire(retire2), .halted(halted2),
    .zero_flag(zf2), .carry_flag(cf2), .dbg_raddr(dbg_raddr2), .dbg_rdata(dbg_rdata2));
  int checks = 0, errors = 0, rcnt = 0;
  logic [15:0] m_reg [8];
  logic [15:0] m_pc;
  logic m_zf, m_cf, m_halt;
  always @(posedge clk) if (rst_n && retire) rcnt++;
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 0;
    m_pc = 0; m_zf = 0; m_cf = 0; m_halt = 0;
  endtask
  // instruction-level semantics: one call per retired instruction
  task automatic model(input logic [15:0] ins);
    logic [2:0] op, rd, rs1, rs2;
    logic [3:0] fn;
    logic [15:0] a, b, se, r;
    logic [16:0] w;
    logic wr;
    op = ins[15:13]; rd = ins[12:10]; rs1 = ins[9:7]; rs2 = ins[6:4]; fn = ins[3:0];
    a = m_reg[rs1]; b = m_reg[rs2]; se = {{9{ins[6]}}, ins[6:0]};
    wr = 0; r = 0;
    case (op)
      3'd0: begin
        m_pc = m_pc + 16'd1;
        if (fn < 8) begin
          wr = 1; m_cf = 0;
          case (fn)
            4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[15:0]; m_cf = w[16]; end
            4'd1: begin r = a - b; m_cf = a < b; end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = (a < b) ? 16'd1 : 16'd0;
            4'd6: r = a << b[3:0];
            default: r = a >> b[3:0];
          endcase
        end
      end
      3'd1: begin
        w = {1'b0, a} + {1'b0, se}; r = w[15:0]; m_cf = w[16]; wr = 1;
        m_pc = m_pc + 16'd1;
      end
      3'd2: m_pc = (m_reg[rd] == a) ? m_pc + 16'd1 + se : m_pc + 16'd1;
      3'd3: m_pc = {3'b000, ins[12:0]};
      3'd7: m_halt = 1;
      default: m_pc = m_pc + 16'd1;
    endcase
    if (wr) begin
      m_zf = r == 0;
      if (rd != 0) m_reg[rd] = r;
    end
  endtask
  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_raddr = 3'(i);
      #1;
      checks++;
      if (dbg_rdata !== m_reg[i]) begin
        errors++;
        $display("FAIL %s r%0d got=%h exp=%h", tag, i, dbg_rdata, m_reg[i]);
      end
    end
  endtask
  // called at a negedge while the core is in FETCH; ack arrives after dly wait cycles
  task automatic exec(input logic [15:0] ins, input int dly);
    logic [15:0] a0;
    a0 = bus.imem_addr;
    checks++;
    if (bus.imem_req !== 1'b1 || a0 !== m_pc) begin
      errors++;
      $display("FAIL fetch_req req=%b addr=%h exp_addr=%h", bus.imem_req, a0, m_pc);
    end
    repeat (dly) begin
      @(negedge clk);
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== a0 || retire !== 1'b0) begin
        errors++;
        $display("FAIL fetch_hold req=%b addr=%h retire=%b exp_addr=%h", bus.imem_req, bus.imem_addr, retire, a0);
      end
    end
    bus.imem_ack = 1; bus.imem_rdata = ins;
    @(negedge clk);
    bus.imem_ack = $urandom_range(0, 1); bus.imem_rdata = 16'($urandom);
    checks++;
    if (retire !== 1'b1 || bus.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL exec_cycle ins=%h retire=%b req=%b exp 1/0", ins, retire, bus.imem_req);
    end
    model(ins);
    #2 bus.imem_ack = 0;
    @(negedge clk);
    checks++;
    if (halted !== m_halt || bus.imem_req !== !m_halt || bus.imem_addr !== m_pc || retire !== 1'b0) begin
      errors++;
      $display("FAIL after_exec ins=%h halted=%b req=%b addr=%h retire=%b exp halted=%b addr=%h",
               ins, halted, bus.imem_req, bus.imem_addr, retire, m_halt, m_pc);
    end
    checks++;
    if (zf !== m_zf || cf !== m_cf) begin
      errors++;
      $display("FAIL flags ins=%h zf=%b cf=%b exp zf=%b cf=%b", ins, zf, cf, m_zf, m_cf);
    end
    check_regs("regfile");
  endtask
  task automatic do_reset();
    rst_n = 0;
    #1;
    model_reset();
    checks++;
    if (bus.imem_req !== 1'b0 || bus2.imem_req !== 1'b0 || halted !== 1'b0 || retire !== 1'b0 ||
        zf !== 1'b0 || cf !== 1'b0 || bus.imem_addr !== 16'h0) begin
      errors++;
      $display("FAIL reset_async req=%b req2=%b halted=%b retire=%b zf=%b cf=%b addr=%h exp all 0",
               bus.imem_req, bus2.imem_req, halted, retire, zf, cf, bus.imem_addr);
    end
    check_regs("reset_regs");
    @(negedge clk);
    bus.imem_ack = 0; bus2.imem_ack = 0;
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0 || retire !== 1'b0) begin
      errors++;
      $display("FAIL reset_release req=%b addr=%h retire=%b exp 1/0000/0", bus.imem_req, bus.imem_addr, retire);
    end
  endtask
  task automatic test_reset();
    do_reset();
  endtask
  task automatic test_param_variant();
    bus2.imem_ack = 1; bus2.imem_rdata = {3'b001, 3'd0, 3'd0, 7'd7};
    @(negedge clk);
    bus2.imem_ack = 0;
    checks++;
    if (retire2 !== 1'b1) begin errors++; $display("FAIL v2_retire got=%b exp=1", retire2); end
    @(negedge clk);
    dbg_raddr2 = 0;
    #1;
    checks++;
    if (dbg_rdata2 !== 16'd7) begin errors++; $display("FAIL v2_r0_writable got=%h exp=0007", dbg_rdata2); end
    bus2.imem_ack = 1; bus2.imem_rdata = {3'b011, 13'h1FFF};
    @(negedge clk);
    bus2.imem_ack = 0;
    @(negedge clk);
    checks++;
    if (bus2.imem_addr !== 8'hFF || bus2.imem_req !== 1'b1) begin
      errors++;
      $display("FAIL v2_jmp_trunc addr=%h req=%b exp ff/1", bus2.imem_addr, bus2.imem_req);
    end
  endtask
  task automatic test_arith();
    int r0c;
    r0c = rcnt;
    exec({3'b001, 3'd1, 3'd0, 7'd5}, 0);
    exec({3'b001, 3'd2, 3'd0, 7'h7D}, 1);
    exec({3'b000, 3'd3, 3'd1, 3'd2, 4'd0}, 0);
    @(negedge clk);
    dbg_raddr = 3;
    #1;
    checks++;
    if (dbg_rdata !== 16'd2 || cf !== 1'b1 || zf !== 1'b0 || rcnt - r0c !== 3) begin
      errors++;
      $display("FAIL add_seq r3=%h cf=%b zf=%b retires=%0d exp 0002/1/0/3", dbg_rdata, cf, zf, rcnt - r0c);
    end
    exec({3'b001, 3'd2, 3'd0, 7'd1}, 0);
    exec({3'b001, 3'd1, 3'd0, 7'd2}, 0);
    exec({3'b000, 3'd4, 3'd2, 3'd1, 4'd1}, 0);
    @(negedge clk);
    dbg_raddr = 4;
    #1;
    checks++;
    if (dbg_rdata !== 16'hFFFF || cf !== 1'b1) begin
      errors++;
      $display("FAIL sub_borrow r4=%h cf=%b exp ffff/1", dbg_rdata, cf);
    end
    exec({3'b000, 3'd5, 3'd1, 3'd1, 4'd1}, 0);
    @(negedge clk);
    dbg_raddr = 5;
    #1;
    checks++;
    if (dbg_rdata !== 16'h0 || zf !== 1'b1 || cf !== 1'b0) begin
      errors++;
      $display("FAIL sub_zero r5=%h zf=%b cf=%b exp 0000/1/0", dbg_rdata, zf, cf);
    end
    exec({3'b001, 3'd0, 3'd0, 7'd7}, 0);
    @(negedge clk);
    dbg_raddr = 0;
    #1;
    checks++;
    if (dbg_rdata !== 16'h0) begin errors++; $display("FAIL zero_reg r0=%h exp=0000", dbg_rdata); end
  endtask
  task automatic test_branch();
    exec({3'b011, 13'd10}, 0);
    exec({3'b010, 3'd0, 3'd0, 7'h7B}, 0);
    @(negedge clk);
    checks++;
    if (bus.imem_addr !== 16'd6) begin errors++; $display("FAIL beq_taken addr=%h exp=0006", bus.imem_addr); end
    exec({3'b011, 13'd10}, 0);
    exec({3'b010, 3'd1, 3'd0, 7'h7B}, 0);
    @(negedge clk);
    checks++;
    if (bus.imem_addr !== 16'd11) begin errors++; $display("FAIL beq_not_taken addr=%h exp=000b", bus.imem_addr); end
  endtask
  task automatic test_ack_delay();
    int r0c;
    r0c = rcnt;
    exec({3'b001, 3'd6, 3'd0, 7'd9}, 3);
    checks++;
    if (rcnt - r0c !== 1) begin errors++; $display("FAIL delay_retire count=%0d exp=1", rcnt - r0c); end
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      exec({3'b000, 3'(i + 1), 3'(i), 3'(i + 2), 4'(i)}, 0);
  endtask
  task automatic test_random();
    logic [15:0] ins;
    for (int n = 0; n < 60; n++) begin
      ins = 16'($urandom);
      if (ins[15:13] == 3'b111) ins[15:13] = 3'b001;
      if (ins[15:13] == 3'b010 && $urandom_range(0, 1) == 1) ins[9:7] = ins[12:10];
      exec(ins, $urandom_range(0, 2));
    end
  endtask
  task automatic test_halt();
    exec(16'hE000, 0);
    for (int i = 0; i < 6; i++) begin
      bus.imem_ack = $urandom_range(0, 1); bus.imem_rdata = {3'b001, 3'd1, 3'd0, 7'd1};
      @(negedge clk);
      checks++;
      if (halted !== 1'b1 || bus.imem_req !== 1'b0 || retire !== 1'b0 || bus.imem_addr !== m_pc) begin
        errors++;
        $display("FAIL halt_hold halted=%b req=%b retire=%b addr=%h exp 1/0/0/%h", halted, bus.imem_req, retire, bus.imem_addr, m_pc);
      end
    end
    bus.imem_ack = 0;
    check_regs("halt_regs");
    @(negedge clk);
    do_reset();
    exec({3'b001, 3'd1, 3'd0, 7'd3}, 0);
  endtask
  task automatic test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL pre_reset_req got=%b exp=1", bus.imem_req); end
    do_reset();
    bus.imem_ack = 1; bus.imem_rdata = {3'b001, 3'd2, 3'd0, 7'd5};
    @(negedge clk);
    bus.imem_ack = 0;
    do_reset();
  endtask
  initial begin
    bus.imem_ack = 0; bus.imem_rdata = 0; bus2.imem_ack = 0; bus2.imem_rdata = 0;
    #1 rst_n = 0;
    @(negedge clk);
    test_reset();
    test_param_variant();
    test_arith();
    test_branch();
    test_ack_delay();
    test_back_to_back();
    test_random();
    test_halt();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
